// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ifetch_unit                                                       |
// | Brief  : Sequential instruction fetch with credit-limited memory requests, |
// |          FWFT instruction FIFO and redirect with stale-response dropping.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_occ_w = c_cnt_w + 1;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [XLEN-1:0]    c_pc_step = XLEN'(4);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic               r_boot;
    logic [XLEN-1:0]    r_fifo_pc   [DEPTH];
    logic [XLEN-1:0]    r_fifo_data [DEPTH];

    logic [c_occ_w-1:0] w_occupancy;
    logic               w_credit;
    logic               w_issue;
    logic               w_drop_rsp;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_out_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_unused_redirect_lsbs;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Occupancy credit: FIFO entries plus in-flight requests never exceed DEPTH,
    // so every accepted request is guaranteed a FIFO slot on return.
    assign w_occupancy   = c_occ_w'(r_count) + c_occ_w'(r_outstanding);
    assign w_credit      = (w_occupancy < c_occ_w'(DEPTH));
    assign mem_req_valid = !reset && !r_boot && !redirect_valid && w_credit;
    assign mem_req_addr  = r_fetch_pc;

    assign w_issue       = mem_req_valid && mem_req_ready;
    assign w_drop_rsp    = mem_rsp_valid && (r_drop != '0);
    assign w_push        = mem_rsp_valid && !w_drop_rsp && !redirect_valid;
    assign w_pop         = instr_valid && instr_ready && !redirect_valid;
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue && !mem_rsp_valid) begin
            w_out_next = r_outstanding + c_one;
        end else if (!w_issue && mem_rsp_valid) begin
            w_out_next = r_outstanding - c_one;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_one;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_boot        <= 1'b1;
        end else begin
            r_boot        <= 1'b0;
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop     <= w_out_next;
            end else begin
                r_count <= w_count_next;
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + c_pc_step;
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_drop_rsp) begin
                    r_drop <= r_drop - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_data[r_wr_ptr] <= mem_rsp_data;
        end
    end

    assign instr_valid = !reset && (r_count != '0);
    assign instr_pc    = r_fifo_pc[r_rd_ptr];
    assign instr_data  = r_fifo_data[r_rd_ptr];

    // A response with nothing outstanding means the memory broke the handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_rsp_valid && (r_outstanding == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ifetch_unit                                                    |
// | Brief  : Bench for ifetch_unit with a queue-based fetch model and memory.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ifetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;
    logic        b_mem_req_valid;
    logic        b_mem_req_ready;
    logic [31:0] b_mem_req_addr;
    logic        b_mem_rsp_valid;
    logic [31:0] b_mem_rsp_data;
    logic        b_instr_valid;
    logic        b_instr_ready;
    logic [31:0] b_instr_data;
    logic [31:0] b_instr_pc;

    req_t        pend[$];
    ent_t        fifo_q[$];
    logic [31:0] acc_addrs[$];
    logic [31:0] seen_pcs[$];
    logic [31:0] b_pcs[$];
    logic [31:0] m_fetch;
    int          m_quiet;
    int          cyc;
    int          n_tests;
    int          n_fail;
    int          p_ready;
    int          p_iready;
    int          lat_min;
    int          lat_max;
    logic        last_iv;
    logic        b_pipe_v;
    logic [31:0] b_pipe_a;

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    ifetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_addr(b_mem_req_addr),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_data(b_mem_rsp_data),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
        .instr_data(b_instr_data), .instr_pc(b_instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset           = 1'b1;
            redirect_valid  = 1'b0;
            mem_rsp_valid   = 1'b0;
            b_mem_rsp_valid = 1'b0;
            mem_req_ready   = 1'b1;
            instr_ready     = 1'b1;
            #1;
            chk1("rst_req_valid", mem_req_valid, 1'b0);
            chk1("rst_instr_valid", instr_valid, 1'b0);
            cyc++;
        end
        pend.delete();
        fifo_q.delete();
        m_fetch  = 32'h0;
        m_quiet  = 1;
        b_pipe_v = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit   rsp;
        bit   expv;
        bit   acc;
        bit   pop;
        req_t r;
        ent_t e;
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_iready);
        rsp            = (pend.size() != 0) && (pend[0].due <= cyc);
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? mem_word(pend[0].addr) : $urandom();
        b_mem_rsp_valid = b_pipe_v;
        b_mem_rsp_data  = mem_word(b_pipe_a);
        #1;
        expv = (m_quiet == 0) && !redir && ((fifo_q.size() + pend.size()) < DEPTH);
        chk1("req_valid", mem_req_valid, expv);
        if (expv) chk("req_addr", mem_req_addr, m_fetch);
        chk1("instr_valid", instr_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) begin
            chk("instr_pc", instr_pc, fifo_q[0].pc);
            chk("instr_data", instr_data, fifo_q[0].data);
        end
        last_iv = instr_valid;
        if (instr_valid) seen_pcs.push_back(instr_pc);
        if (mem_req_valid && mem_req_ready) acc_addrs.push_back(mem_req_addr);

        acc = expv && mem_req_ready;
        pop = (fifo_q.size() != 0) && instr_ready;
        if (redir) fifo_q.delete();
        else if (pop) void'(fifo_q.pop_front());
        if (rsp) begin
            r = pend.pop_front();
            if (!r.stale && !redir) begin
                e.pc   = r.pc;
                e.data = mem_word(r.pc);
                fifo_q.push_back(e);
            end
        end
        if (redir) begin
            for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
        end
        if (acc) begin
            r.addr  = mem_req_addr;
            r.pc    = m_fetch;
            r.due   = cyc + int'($urandom_range(lat_max, lat_min));
            r.stale = 1'b0;
            pend.push_back(r);
            m_fetch = m_fetch + 32'd4;
        end
        if (m_quiet > 0) m_quiet--;

        if (b_instr_valid && (b_pcs.size() < 3)) b_pcs.push_back(b_instr_pc);
        b_pipe_v = b_mem_req_valid;
        b_pipe_a = b_mem_req_addr;
        cyc++;
    endtask

    initial begin
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        mem_req_ready    = 1'b1;
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = 32'h0;
        instr_ready      = 1'b1;
        b_redirect_valid = 1'b0;
        b_redirect_pc    = 32'h0;
        b_mem_req_ready  = 1'b1;
        b_mem_rsp_valid  = 1'b0;
        b_mem_rsp_data   = 32'h0;
        b_instr_ready    = 1'b1;
        b_pipe_v         = 1'b0;
        b_pipe_a         = 32'h0;
        m_fetch          = 32'h0;
        m_quiet          = 0;
        cyc              = 0;
        n_tests          = 0;
        n_fail           = 0;
        last_iv          = 1'b0;
        p_ready          = 100;
        p_iready         = 100;
        lat_min          = 1;
        lat_max          = 1;

        // Reset held three cycles, then the first two fetch addresses.
        do_reset(3);
        acc_addrs.delete();
        repeat (4) cycle(1'b0, 32'h0);
        chk("t1_first_addr", qat(acc_addrs, 0), 32'h0);
        chk("t1_second_addr", qat(acc_addrs, 1), 32'h4);

        // Streaming with one-cycle memory: one instruction every cycle.
        seen_pcs.delete();
        repeat (20) cycle(1'b0, 32'h0);
        chk("t2_throughput", 32'(seen_pcs.size()), 32'd20);
        chk("t2_last_pc", qat(seen_pcs, 19), 32'h50);

        // Core stalled: credits stop fetch after DEPTH requests.
        p_iready = 0;
        do_reset(2);
        acc_addrs.delete();
        repeat (12) cycle(1'b0, 32'h0);
        chk("t3_req_count", 32'(acc_addrs.size()), 32'd4);
        chk("t3_last_addr", qat(acc_addrs, 3), 32'hC);
        chk1("t3_req_stalled", mem_req_valid, 1'b0);
        p_iready = 100;
        seen_pcs.delete();
        acc_addrs.delete();
        repeat (8) cycle(1'b0, 32'h0);
        chk("t3_drain_first", qat(seen_pcs, 0), 32'h0);
        chk("t3_drain_fourth", qat(seen_pcs, 3), 32'hC);
        chk("t3_resume_addr", qat(acc_addrs, 0), 32'h10);

        // Latency 3, two requests in flight, redirect to an unaligned PC.
        lat_min = 3;
        lat_max = 3;
        do_reset(2);
        repeat (3) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h102);
        acc_addrs.delete();
        seen_pcs.delete();
        repeat (10) cycle(1'b0, 32'h0);
        chk("t4_next_req", qat(acc_addrs, 0), 32'h100);
        chk("t4_next_pc", qat(seen_pcs, 0), 32'h100);

        // Redirect coinciding with a response and a pop, one request still pending.
        lat_min = 2;
        lat_max = 2;
        do_reset(2);
        repeat (10) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h200);
        chk1("t5_head_at_redirect", last_iv, 1'b1);
        seen_pcs.delete();
        cycle(1'b0, 32'h0);
        chk1("t5_flushed", last_iv, 1'b0);
        repeat (10) cycle(1'b0, 32'h0);
        chk("t5_first_new_pc", qat(seen_pcs, 0), 32'h200);

        // Randomized traffic: variable latency, backpressure and redirects.
        lat_min  = 1;
        lat_max  = 4;
        p_ready  = 70;
        p_iready = 70;
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(2);
            cycle($urandom_range(99) < 3, $urandom());
        end

        // PC wrap-around on the second instance.
        chk("t6_pc0", qat(b_pcs, 0), 32'hFFFF_FFF8);
        chk("t6_pc1", qat(b_pcs, 1), 32'hFFFF_FFFC);
        chk("t6_pc2", qat(b_pcs, 2), 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
